// File: rtl/job_controller_pkg.sv
// Shared types and constants for the CAPI PSL job-interface controller.
package job_controller_pkg;

  // Job command codes recognised on the PSL job interface.
  typedef enum logic [7:0] {
    CMD_RESET = 8'h80,
    CMD_START = 8'h90
  } job_command_e;

  // Controller job state.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RUNNING    = 2'd1,
    ST_COMPLETING = 2'd2
  } job_state_e;

  // Error code reported when the running-job watchdog expires.
  localparam logic [63:0] ERR_TIMEOUT = 64'h1;

  // Width of the watchdog cycle counter.
  localparam int WD_WIDTH = 32;

endpackage : job_controller_pkg

// File: rtl/job_controller_if.sv
// Job/core handshake bundle between the PSL job interface, the
// controller and the AFU core.
interface job_controller_if #(
  parameter int ERROR_WIDTH = 64
);
  // PSL job interface
  logic                   job_valid;
  logic [7:0]             job_command;
  logic [63:0]            job_address;
  logic                   job_running;
  logic                   job_done;
  logic [ERROR_WIDTH-1:0] job_error;
  logic                   job_cack;
  logic                   job_yield;
  logic                   timebase_request;
  // AFU core side
  logic                   core_start;
  logic                   core_reset;
  logic [63:0]            core_wed;
  logic                   core_done;
  logic [ERROR_WIDTH-1:0] core_error;

  // Controller view
  modport slave (
    input  job_valid, job_command, job_address, core_done, core_error,
    output job_running, job_done, job_error, job_cack, job_yield,
           timebase_request, core_start, core_reset, core_wed
  );

  // Host/core (environment) view
  modport master (
    output job_valid, job_command, job_address, core_done, core_error,
    input  job_running, job_done, job_error, job_cack, job_yield,
           timebase_request, core_start, core_reset, core_wed
  );

endinterface : job_controller_if

// File: rtl/job_controller_delay_line.sv
// Fixed-depth shift register carrying the completion token.
// flush_i discards everything already in flight while the entry stage
// still captures din_i, so a new token can replace pending ones.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the token one stage per cycle; synchronous clear empties the line.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= flush_i ? '0 : stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule : delay_line

// File: rtl/job_controller.sv
// CAPI PSL job-interface controller: decodes RESET/START, tracks the job
// state, hands the WED to the core and reports completion through a
// delayed one-cycle done pulse with an error code.
module job_controller
  import job_controller_pkg::*;
#(
  parameter int DONE_DELAY     = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ERROR_WIDTH    = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  job_controller_if.slave  bus
);

  localparam int TOK_W = ERROR_WIDTH + 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT =
    WD_EN ? WD_WIDTH'(TIMEOUT_CYCLES - 1) : {WD_WIDTH{1'b0}};
  localparam logic [ERROR_WIDTH-1:0] ERR_TIMEOUT_W = ERROR_WIDTH'(ERR_TIMEOUT);

  job_state_e             state_q, state_d;
  logic                   job_running_q, job_running_d;
  logic                   job_done_q, job_done_d;
  logic [ERROR_WIDTH-1:0] job_error_q, job_error_d;
  logic                   core_start_q, core_start_d;
  logic                   core_reset_q, core_reset_d;
  logic [63:0]            core_wed_q, core_wed_d;
  logic [WD_WIDTH-1:0]    wd_q, wd_d;

  logic                   cmd_reset_s;
  logic                   cmd_start_s;
  logic                   wd_expire_s;
  logic                   tok_valid_s;
  logic [ERROR_WIDTH-1:0] tok_error_s;
  logic                   flush_s;
  logic [TOK_W-1:0]       dly_out_s;
  logic                   emit_valid_s;
  logic [ERROR_WIDTH-1:0] emit_error_s;

  assign cmd_reset_s  = bus.job_valid && (bus.job_command == CMD_RESET);
  assign cmd_start_s  = bus.job_valid && (bus.job_command == CMD_START);
  assign wd_expire_s  = WD_EN && (wd_q == WD_LIMIT);
  assign emit_valid_s = dly_out_s[TOK_W-1];
  assign emit_error_s = dly_out_s[ERROR_WIDTH-1:0];

  // Completion token travels DONE_DELAY stages before becoming job_done.
  delay_line #(
    .DEPTH (DONE_DELAY),
    .WIDTH (TOK_W)
  ) u_delay_line (
    .clk_i   (clock),
    .clr_ni  (reset_n),
    .flush_i (flush_s),
    .din_i   ({tok_valid_s, tok_error_s}),
    .dout_o  (dly_out_s)
  );

  // State and output registers, synchronously cleared by reset_n.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      job_running_q <= 1'b0;
      job_done_q    <= 1'b0;
      job_error_q   <= '0;
      core_start_q  <= 1'b0;
      core_reset_q  <= 1'b0;
      core_wed_q    <= 64'h0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      job_running_q <= job_running_d;
      job_done_q    <= job_done_d;
      job_error_q   <= job_error_d;
      core_start_q  <= core_start_d;
      core_reset_q  <= core_reset_d;
      core_wed_q    <= core_wed_d;
      wd_q          <= wd_d;
    end
  end

  // Next-state logic: RESET beats core_done, core_done beats the watchdog.
  always_comb begin
    state_d       = state_q;
    job_running_d = job_running_q;
    job_done_d    = 1'b0;
    job_error_d   = '0;
    core_start_d  = 1'b0;
    core_reset_d  = 1'b0;
    core_wed_d    = core_wed_q;
    wd_d          = wd_q;
    tok_valid_s   = 1'b0;
    tok_error_s   = '0;
    flush_s       = 1'b0;

    if (cmd_reset_s) begin
      // Replace any pending completion with an error-free one.
      core_reset_d  = 1'b1;
      job_running_d = 1'b0;
      state_d       = ST_COMPLETING;
      tok_valid_s   = 1'b1;
      tok_error_s   = '0;
      flush_s       = 1'b1;
    end else begin
      job_done_d  = emit_valid_s;
      job_error_d = emit_valid_s ? emit_error_s : '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_start_s) begin
            core_start_d  = 1'b1;
            job_running_d = 1'b1;
            core_wed_d    = bus.job_address;
            wd_d          = '0;
            state_d       = ST_RUNNING;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUNNING: begin
          if (bus.core_done) begin
            job_running_d = 1'b0;
            tok_valid_s   = 1'b1;
            tok_error_s   = bus.core_error;
            state_d       = ST_COMPLETING;
          end else if (wd_expire_s) begin
            job_running_d = 1'b0;
            tok_valid_s   = 1'b1;
            tok_error_s   = ERR_TIMEOUT_W;
            state_d       = ST_COMPLETING;
          end else begin
            wd_d = wd_q + WD_WIDTH'(1);
          end
        end
        ST_COMPLETING: begin
          // Leave only after the done pulse, so a START alongside it is ignored.
          if (job_done_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COMPLETING;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          job_running_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.job_running      = job_running_q;
  assign bus.job_done         = job_done_q;
  assign bus.job_error        = job_error_q;
  assign bus.core_start       = core_start_q;
  assign bus.core_reset       = core_reset_q;
  assign bus.core_wed         = core_wed_q;
  assign bus.job_cack         = 1'b0;
  assign bus.job_yield        = 1'b0;
  assign bus.timebase_request = 1'b0;

endmodule : job_controller

// File: tb/tb_job_controller.sv
// Directed self-checking bench for job_controller. Two instances:
// dut_a (DONE_DELAY=1, no watchdog) and dut_b (DONE_DELAY=4, TIMEOUT_CYCLES=16).
module tb_job_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_a = 1'b1;
  logic        en_b = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [63:0] addr = 64'h0;
  logic        cdone = 1'b0;
  logic [63:0] cerr = 64'h0;

  int n_assert = 0;
  int n_fail   = 0;

  job_controller_if #(.ERROR_WIDTH(64)) if_a ();
  job_controller_if #(.ERROR_WIDTH(64)) if_b ();

  assign if_a.job_valid   = en_a & valid;
  assign if_a.job_command = cmd;
  assign if_a.job_address = addr;
  assign if_a.core_done   = en_a & cdone;
  assign if_a.core_error  = cerr;
  assign if_b.job_valid   = en_b & valid;
  assign if_b.job_command = cmd;
  assign if_b.job_address = addr;
  assign if_b.core_done   = en_b & cdone;
  assign if_b.core_error  = cerr;

  job_controller #(.DONE_DELAY(1), .TIMEOUT_CYCLES(0), .ERROR_WIDTH(64)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  job_controller #(.DONE_DELAY(4), .TIMEOUT_CYCLES(16), .ERROR_WIDTH(64)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held 3 cycles with a START presented to both instances.
    valid = 1'b1; cmd = 8'h90; addr = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_a_start", 64'(if_a.core_start), 64'h0);
      check("rst_b_start", 64'(if_b.core_start), 64'h0);
    end
    check("rst_a_running", 64'(if_a.job_running), 64'h0);
    check("rst_a_done", 64'(if_a.job_done), 64'h0);
    check("rst_a_error", if_a.job_error, 64'h0);
    check("rst_a_wed", if_a.core_wed, 64'h0);
    check("rst_a_creset", 64'(if_a.core_reset), 64'h0);
    check("rst_a_ties", 64'({if_a.job_cack, if_a.job_yield, if_a.timebase_request}), 64'h0);
    check("rst_b_running", 64'(if_b.job_running), 64'h0);
    check("rst_b_wed", if_b.core_wed, 64'h0);
    valid = 1'b0;
    reset_n = 1'b1;
    step();
    check("idle_a_running", 64'(if_a.job_running), 64'h0);

    // dut_a: START then core_done four cycles later.
    en_b = 1'b0;
    valid = 1'b1; cmd = 8'h90; addr = 64'hDEAD_0000;
    step();
    valid = 1'b0;
    check("t1_start", 64'(if_a.core_start), 64'h1);
    check("t1_running", 64'(if_a.job_running), 64'h1);
    check("t1_wed", if_a.core_wed, 64'hDEAD_0000);
    step();
    check("t1_start_once", 64'(if_a.core_start), 64'h0);
    step();
    step();
    cdone = 1'b1; cerr = 64'h0;
    step();
    cdone = 1'b0;
    check("t1_running_fall", 64'(if_a.job_running), 64'h0);
    check("t1_done_early", 64'(if_a.job_done), 64'h0);
    step();
    check("t1_done", 64'(if_a.job_done), 64'h1);
    check("t1_error", if_a.job_error, 64'h0);
    step();
    check("t1_done_clear", 64'(if_a.job_done), 64'h0);

    // dut_a: START while running is ignored; done reports core_error.
    valid = 1'b1; cmd = 8'h90; addr = 64'hA1;
    step();
    check("t2_start", 64'(if_a.core_start), 64'h1);
    addr = 64'hBBBB;
    step();
    valid = 1'b0;
    check("t2_no_start", 64'(if_a.core_start), 64'h0);
    check("t2_wed_hold", if_a.core_wed, 64'hA1);
    check("t2_running", 64'(if_a.job_running), 64'h1);
    cdone = 1'b1; cerr = 64'h7;
    step();
    cdone = 1'b0; cerr = 64'h0;
    check("t2_running_fall", 64'(if_a.job_running), 64'h0);
    step();
    check("t2_done", 64'(if_a.job_done), 64'h1);
    check("t2_error", if_a.job_error, 64'h7);
    step();
    check("t2_done_clear", 64'(if_a.job_done), 64'h0);
    check("t2_error_clear", if_a.job_error, 64'h0);

    // dut_a: unknown command and stray core_done in IDLE are ignored.
    valid = 1'b1; cmd = 8'h55;
    step();
    valid = 1'b0;
    check("t3_no_start", 64'(if_a.core_start), 64'h0);
    check("t3_no_creset", 64'(if_a.core_reset), 64'h0);
    cdone = 1'b1; cerr = 64'h9;
    step();
    cdone = 1'b0; cerr = 64'h0;
    check("t3_running", 64'(if_a.job_running), 64'h0);
    step();
    check("t3_no_done1", 64'(if_a.job_done), 64'h0);
    step();
    check("t3_no_done2", 64'(if_a.job_done), 64'h0);

    // dut_a: RESET and core_done(err 5) together -> single done, error 0.
    valid = 1'b1; cmd = 8'h90; addr = 64'hC0;
    step();
    valid = 1'b0;
    check("t4_running", 64'(if_a.job_running), 64'h1);
    step();
    valid = 1'b1; cmd = 8'h80; cdone = 1'b1; cerr = 64'h5;
    step();
    valid = 1'b0; cdone = 1'b0; cerr = 64'h0;
    check("t4_creset", 64'(if_a.core_reset), 64'h1);
    check("t4_running_fall", 64'(if_a.job_running), 64'h0);
    check("t4_done_early", 64'(if_a.job_done), 64'h0);
    step();
    check("t4_done", 64'(if_a.job_done), 64'h1);
    check("t4_error", if_a.job_error, 64'h0);
    check("t4_creset_pulse", 64'(if_a.core_reset), 64'h0);
    step();
    check("t4_done_once1", 64'(if_a.job_done), 64'h0);
    step();
    check("t4_done_once2", 64'(if_a.job_done), 64'h0);
    check("t4_wed_hold", if_a.core_wed, 64'hC0);

    // dut_b (DONE_DELAY=4): RESET during RUNNING.
    en_a = 1'b0; en_b = 1'b1;
    valid = 1'b1; cmd = 8'h90; addr = 64'hE0;
    step();
    valid = 1'b0;
    check("t5_start", 64'(if_b.core_start), 64'h1);
    step();
    step();
    check("t5_running", 64'(if_b.job_running), 64'h1);
    valid = 1'b1; cmd = 8'h80;
    step();
    valid = 1'b0;
    check("t5_creset", 64'(if_b.core_reset), 64'h1);
    check("t5_running_fall", 64'(if_b.job_running), 64'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t5_done_wait", 64'(if_b.job_done), 64'h0);
    end
    step();
    check("t5_done", 64'(if_b.job_done), 64'h1);
    check("t5_error", if_b.job_error, 64'h0);
    step();
    check("t5_done_clear", 64'(if_b.job_done), 64'h0);

    // dut_b (TIMEOUT_CYCLES=16): watchdog expiry.
    valid = 1'b1; cmd = 8'h90; addr = 64'hF0;
    step();
    valid = 1'b0;
    check("t6_running", 64'(if_b.job_running), 64'h1);
    for (int i = 1; i < 16; i++) begin
      step();
    end
    check("t6_running_last", 64'(if_b.job_running), 64'h1);
    step();
    check("t6_running_fall", 64'(if_b.job_running), 64'h0);
    check("t6_done_early", 64'(if_b.job_done), 64'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t6_done_wait", 64'(if_b.job_done), 64'h0);
    end
    step();
    check("t6_done", 64'(if_b.job_done), 64'h1);
    check("t6_error", if_b.job_error, 64'h1);
    step();
    check("t6_done_clear", 64'(if_b.job_done), 64'h0);
    check("t6_wed", if_b.core_wed, 64'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_job_controller

// File: doc/job_controller.md
Name: job_controller

Overview:
- Parametrised CAPI PSL job-interface controller for AFUs.
- Decodes job commands (RESET, START) and tracks job state.
- Hands the WED pointer and a start pulse to the AFU core.
- Reports completion via a programmable-latency done pulse carrying an error code, with an optional watchdog timeout.

Parameters:
DONE_DELAY, 1, cycles from completion event to job_done pulse; legal range >=1.
TIMEOUT_CYCLES, 0, running-job watchdog limit in cycles; 0 disables the watchdog.
ERROR_WIDTH, 64, width of job_error/core_error.

Ports:
clock  in  1  sole clock, all logic rising-edge.
reset_n  in  1  synchronous active-low reset.
job_valid  in  1  job command valid strobe (one cycle).
job_command  in  8  job command code (RESET=0x80, START=0x90, others ignored).
job_address  in  64  WED pointer, sampled with START.
job_running  out  1  high while a job is active.
job_done  out  1  one-cycle completion pulse.
job_error  out  ERROR_WIDTH  error code, valid only while job_done=1, else 0.
job_cack, job_yield, timebase_request  out  1 each  tied 0.
core_start  out  1  one-cycle pulse to core on accepted START.
core_reset  out  1  one-cycle pulse to core on accepted RESET.
core_wed  out  64  latched WED pointer.
core_done  in  1  core completion strobe.
core_error  in  ERROR_WIDTH  core error code, sampled with core_done.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs are 0 next cycle; state=IDLE; delay line and watchdog counter cleared.
  - Reset overrides any in-flight command or pending done.
- States: IDLE, RUNNING, COMPLETING.
- RESET command (job_valid && job_command==0x80), accepted in any state:
  - Next cycle: core_reset=1, job_running=0, state=COMPLETING, pending error=0.
  - Any previously pending done is discarded and replaced.
- START command (0x90):
  - In IDLE: next cycle core_start=1, job_running=1, core_wed=job_address, watchdog=0, state=RUNNING.
  - In RUNNING or COMPLETING: ignored, no outputs change.
- Any other command code: ignored.
- core_done=1 in RUNNING:
  - Next cycle: job_running=0, pending error=core_error, state=COMPLETING.
  - core_done outside RUNNING is ignored.
- Watchdog: in RUNNING the counter increments each cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no core_done, the block behaves as core_done with error=ERR_TIMEOUT.
- COMPLETING timing:
  - job_done=1 exactly DONE_DELAY cycles after the cycle in which the completion event was sampled.
  - job_error=pending error in that same cycle; then state=IDLE.
  - DONE_DELAY=1 gives done on the cycle after job_running falls.
- Simultaneous events in one cycle:
  - RESET command wins over core_done and over watchdog expiry.
  - core_done wins over watchdog expiry.
  - START in the same cycle as done emission is ignored; the host must wait for done.
- core_wed holds its value until the next accepted START; it is cleared only by reset_n.
- job_done never asserts for more than one consecutive cycle.

Decomposition:
- CAPI package receives:
  - JobCommand enum (RESET=8'h80, START=8'h90).
  - JobState enum (IDLE, RUNNING, COMPLETING).
  - Constant ERR_TIMEOUT = 64'h1.
- One sub-module, delay_line: parametrised DEPTH/WIDTH shift register with synchronous active-low clear. It carries the {valid, error} completion token for DONE_DELAY stages and generalises the single-stage done shifter.

Test Plan:
- reset_n=0 for 3 cycles with job_valid=1, START -> all outputs 0, state IDLE, no core_start.
- DONE_DELAY=1: START addr=64'hDEAD_0000, then core_done with core_error=0 four cycles later:
  - core_start pulses once; core_wed=64'hDEAD_0000.
  - job_running falls the cycle after core_done; job_done=1 with job_error=0 one cycle after that.
- DONE_DELAY=4, RESET during RUNNING -> core_reset pulse, job_running=0 next cycle, job_done exactly 4 cycles after RESET is sampled, job_error=0.
- TIMEOUT_CYCLES=16: START and never assert core_done -> job_running falls after 16 running cycles, then job_done with job_error=ERR_TIMEOUT (64'h1).
- RESET and core_done (core_error=64'h5) in the same cycle -> exactly one job_done, with job_error=0.
- START during RUNNING with a different addr -> ignored: core_wed unchanged, no core_start, and the subsequent done is reported normally.
